// File: rtl/imem_fetch_pkg.sv
// ---- imem_fetch_pkg : shared types for the instruction-fetch sequencer | rev 1.0 ----
`default_nettype none

package imem_fetch_pkg;

  localparam int          INSN_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INSN_W-1:0] insn;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/imem_fetch_queue.sv
// ---- fetch_queue : flushable shift FIFO whose head is always slot 0 (registered) | rev 1.0 ----
`default_nettype none

module fetch_queue
  import imem_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     entry_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     slot_q [DEPTH];
  fetch_entry_t     slot_d [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] wr_idx;
  logic             do_pop;
  logic             do_push;

  always_comb begin
    do_pop  = pop_i && (count_q != '0) && !flush_i;
    do_push = push_i && (count_q != CNT_W'(DEPTH)) && !flush_i;
    wr_idx  = count_q - CNT_W'(do_pop);
    slot_d  = slot_q;
    // Popping shifts everything one slot toward the head; the vacated tail is left stale.
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        slot_d[i] = slot_q[i + 1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && (wr_idx == CNT_W'(i))) begin
        slot_d[i] = entry_i;
      end
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (flush_i) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      slot_q  <= slot_d;
      count_q <= count_d;
    end
  end

  assign head_o  = slot_q[0];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
// ---- imem_fetch_ctrl : owns the fetch PC, requests words and hands them to decode | rev 1.0 ----
`default_nettype none

module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       imem_addr_o,
  output logic              imem_en_o,
  input  logic              imem_gnt_i,
  input  logic [INSN_W-1:0] imem_rdata_i,
  input  logic              redirect_valid_i,
  input  logic [31:0]       redirect_pc_i,
  input  logic              halt_req_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INSN_W-1:0] inst_data_o,
  output logic [31:0]       inst_pc_o,
  output logic              fault_o
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;

  fetch_state_e     state_q;
  logic [31:0]      fetch_pc_q;
  logic             fault_q;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             redir_aligned;
  fetch_entry_t     head;
  fetch_entry_t     new_entry;

  // Request enable depends only on registered state, never on grant or ready.
  assign imem_en_o     = (state_q == RUN) && (count < CNT_W'(QDEPTH));
  assign redir_aligned = (redirect_pc_i[1:0] == 2'b00);
  assign push          = imem_en_o && imem_gnt_i && !redirect_valid_i && !halt_req_i;
  assign pop           = inst_valid_o && inst_ready_i && !redirect_valid_i;
  assign new_entry     = '{pc: fetch_pc_q, insn: imem_rdata_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      fault_q    <= 1'b0;
    end else if (redirect_valid_i) begin
      if (redir_aligned) begin
        fetch_pc_q <= redirect_pc_i;
        state_q    <= halt_req_i ? HALT : RUN;
        fault_q    <= 1'b0;
      end else begin
        state_q <= FAULT;
        fault_q <= 1'b1;
      end
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (halt_req_i) begin
            state_q <= HALT;
          end else if (push) begin
            fetch_pc_q <= fetch_pc_q + PC_STEP;
          end
        end
        HALT: begin
          if (!halt_req_i) begin
            state_q <= RUN;
          end
        end
        FAULT:   state_q <= FAULT;
        default: state_q <= BOOT;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid_i),
    .push_i  (push),
    .entry_i (new_entry),
    .pop_i   (pop),
    .head_o  (head),
    .valid_o (inst_valid_o),
    .count_o (count)
  );

  assign imem_addr_o = fetch_pc_q;
  assign inst_data_o = head.insn;
  assign inst_pc_o   = head.pc;
  assign fault_o     = fault_q;

endmodule

`default_nettype wire

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch sequencer between the core's decode stage and the word-addressed instruction memory. Owns the fetch PC, issues one word read per granted cycle, buffers fetched words with their PCs in a small flushable queue, and presents them to decode over a valid/ready handshake. Handles branch/jump redirects, halt requests and misaligned-target faults so the datapath never drives the instruction memory address directly.

## Interface
- RESET_PC, 32'h0000_0000: fetch address loaded on reset; bits [1:0] must be 0.
- QDEPTH, 2: fetch-queue entries; power of two, at least 2.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory; always word aligned.
- imem_en  out  1  fetch request this cycle.
- imem_gnt  in  1  memory accepts the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word (combinational read).
- redirect_valid  in  1  redirect the fetch stream this cycle.
- redirect_pc  in  32  new fetch target.
- halt_req  in  1  level; suspend fetching while high.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode consumes the head.
- inst_data  out  32  head instruction word.
- inst_pc  out  32  head instruction address.
- fault  out  1  misaligned redirect pending.

## Operation
- FSM states: BOOT, RUN, HALT, FAULT. Reset enters BOOT.
- BOOT: imem_en=0 for exactly one cycle, then RUN. A redirect in BOOT is accepted (see below) and also moves to RUN.
- RUN: imem_en = (count < QDEPTH). If imem_en && imem_gnt: push {fetch_pc, imem_rdata}, then fetch_pc += 4. No push while full, even if a pop happens in the same cycle (no full-bypass).
- RUN -> HALT when halt_req=1 and no redirect. HALT: imem_en=0; the queue keeps draining to decode. HALT -> RUN when halt_req=0.
- Redirect (redirect_valid=1), any state: flush the queue (count=0), and suppress push and pop that cycle. If redirect_pc[1:0]==0: fetch_pc=redirect_pc, next state RUN, or HALT if halt_req=1. Otherwise: fetch_pc is unchanged, next state FAULT, fault=1.
- FAULT: imem_en=0, fault=1 and the queue stays empty. Only an aligned redirect leaves FAULT; halt_req is ignored in FAULT.
- Priority, highest first: rst, redirect, halt_req, push/pop.
- Queue: inst_valid = (count != 0); pop on inst_valid && inst_ready. Simultaneous push and pop leaves count unchanged. inst_data and inst_pc hold their values while inst_valid=1 && inst_ready=0.
- Widths and arithmetic: count is $clog2(QDEPTH)+1 bits. fetch_pc is a 32-bit modulo add, so 32'hFFFF_FFFC + 4 wraps to 0 with no flag. imem_addr = fetch_pc.

## Timing
- Reset values: imem_addr=RESET_PC, imem_en=0, inst_valid=0, inst_data=0, inst_pc=0, fault=0, count=0, state=BOOT.
- imem_addr and inst_* come from registers. imem_en is combinational from state and count only, with no path from imem_gnt or inst_ready.
- Latency: with rst deasserted before edge 0, edge 0 leaves BOOT. The first request is in cycle 1. With a grant in cycle 1, inst_valid=1 in cycle 2 at inst_pc=RESET_PC.
- Redirect at edge N: the old stream is gone in cycle N+1. The first new-target request is in cycle N+1, and its word reaches decode in N+2.
- Sustained throughput is 1 word/cycle when imem_gnt=1 and inst_ready=1 continuously.
- An async rst mid-operation clears the queue and all outputs immediately. A fetch granted in the same cycle is dropped.

## Structure
- Package imem_fetch_pkg: the state enum fetch_state_e {BOOT, RUN, HALT, FAULT}, INSN_W=32, PC_STEP=4, and a queue entry struct {pc, insn}.
- One sub-module, fetch_queue: a parameterized synchronous FIFO with a flush input, a count output, and a registered head. The FSM and PC logic live in imem_fetch_ctrl.

## Test plan
- Reset, then imem_gnt=1 and inst_ready=1 held -> BOOT idles one cycle; decode receives PCs 0x0, 0x4, 0x8 with matching imem_rdata, one per cycle from cycle 2.
- inst_ready=0 with QDEPTH=2 -> exactly two words are queued, then imem_en=0. Raising inst_ready resumes the stream at the next PC with no duplicates or gaps.
- Redirect to 0x100 while the queue holds 2 entries -> inst_valid=0 next cycle; the next delivered inst_pc=0x100, followed by 0x104.
- Redirect to 0x102 -> fault=1, imem_en=0 and the queue stays empty. An aligned redirect to 0x200 clears fault and delivers 0x200.
- halt_req=1 with a full queue -> no requests, both entries drain. Releasing halt_req resumes at the next sequential PC. A redirect while halted with halt_req still high stays in HALT at the new target.
- Start at RESET_PC=32'hFFFF_FFF8 with continuous grants -> PCs FFFF_FFF8, FFFF_FFFC, then 0x0. Asserting rst mid-stream -> all outputs are at reset values before the next clock edge.
